// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_pkg;

    typedef enum logic {StIdle, StBusy} mdu_state_e;

    localparam int unsigned MULT_CYCLES_DEF = 4;
    localparam int unsigned DIV_CYCLES_DEF  = 32;
    localparam int unsigned REG_IDX_W       = 5;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Decode/EX/MEM status in, stage-register controls out.
interface pipeline_ctrl_if
    import pipe_pkg::*;
();
    logic [REG_IDX_W-1:0] id_rs;
    logic [REG_IDX_W-1:0] id_rt;
    logic                 id_uses_rs;
    logic                 id_uses_rt;
    logic                 id_is_mdu;
    logic                 id_is_div;
    logic                 id_uses_hilo;
    logic                 ex_memread;
    logic [REG_IDX_W-1:0] ex_rd;
    logic                 ex_branch_taken;
    logic                 mem_req;
    logic                 mem_ready;

    logic                 pc_write;
    logic                 ifid_write;
    logic                 idex_write;
    logic                 exmem_write;
    logic                 memwb_write;
    logic                 ifid_flush;
    logic                 idex_flush;
    logic                 exmem_flush;
    logic                 memwb_flush;
    logic                 mdu_start;
    logic                 mdu_busy;
    logic [31:0]          stall_cycles;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_mdu, id_is_div, id_uses_hilo,
               ex_memread, ex_rd, ex_branch_taken, mem_req, mem_ready,
        input  pc_write, ifid_write, idex_write, exmem_write, memwb_write,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               mdu_start, mdu_busy, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_mdu, id_is_div, id_uses_hilo,
               ex_memread, ex_rd, ex_branch_taken, mem_req, mem_ready,
        output pc_write, ifid_write, idex_write, exmem_write, memwb_write,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               mdu_start, mdu_busy, stall_cycles
    );

endinterface

// File: rtl/pipeline_ctrl_mdu_sequencer.sv
// Tracks the multiply/divide unit busy window after each launch pulse.
module mdu_sequencer
    import pipe_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W       = 6
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_is_div,
    output logic o_busy
);

    localparam logic [CNT_W-1:0] MultLoad = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DivLoad  = CNT_W'(DIV_CYCLES - 1);

    mdu_state_e       r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Counter holds the number of busy cycles still to come after the current one.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_next = StBusy;
                    w_cnt_next   = i_is_div ? DivLoad : MultLoad;
                end
            end
            StBusy: begin
                if (r_cnt == '0) w_state_next = StIdle;
                else             w_cnt_next   = r_cnt - 1'b1;
            end
        endcase
    end

    assign o_busy = (r_state == StBusy);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard priority (freeze > branch > MDU/load-use > normal) and stall-cycle counter.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W       = 6
) (
    input  logic            clk,
    input  logic            rst,
    pipeline_ctrl_if.slave  bus
);

    logic        w_freeze;
    logic        w_load_use;
    logic        w_mdu_haz;
    logic        w_mdu_busy;
    logic [31:0] r_stall_cycles;

    assign w_freeze   = bus.mem_req && !bus.mem_ready;
    assign w_load_use = bus.ex_memread && (bus.ex_rd != '0) &&
                        ((bus.id_uses_rs && (bus.id_rs == bus.ex_rd)) ||
                         (bus.id_uses_rt && (bus.id_rt == bus.ex_rd)));
    assign w_mdu_haz  = w_mdu_busy && (bus.id_is_mdu || bus.id_uses_hilo);

    always_comb begin
        bus.pc_write    = 1'b1;
        bus.ifid_write  = 1'b1;
        bus.idex_write  = 1'b1;
        bus.exmem_write = 1'b1;
        bus.memwb_write = 1'b1;
        bus.ifid_flush  = 1'b0;
        bus.idex_flush  = 1'b0;
        bus.exmem_flush = 1'b0;
        bus.memwb_flush = 1'b0;
        bus.mdu_start   = 1'b0;
        if (rst) begin
            bus.pc_write    = 1'b0;
            bus.ifid_write  = 1'b0;
            bus.idex_write  = 1'b0;
            bus.exmem_write = 1'b0;
            bus.memwb_write = 1'b0;
            bus.ifid_flush  = 1'b1;
            bus.idex_flush  = 1'b1;
            bus.exmem_flush = 1'b1;
            bus.memwb_flush = 1'b1;
        end else if (w_freeze) begin
            bus.pc_write    = 1'b0;
            bus.ifid_write  = 1'b0;
            bus.idex_write  = 1'b0;
            bus.exmem_write = 1'b0;
            bus.memwb_write = 1'b0;
        end else if (bus.ex_branch_taken) begin
            bus.ifid_flush  = 1'b1;
            bus.idex_flush  = 1'b1;
        end else if (w_mdu_haz || w_load_use) begin
            // Hold PC and IF/ID, inject a bubble into ID/EX.
            bus.pc_write    = 1'b0;
            bus.ifid_write  = 1'b0;
            bus.idex_flush  = 1'b1;
        end else begin
            bus.mdu_start   = bus.id_is_mdu;
        end
    end

    mdu_sequencer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_mdu_sequencer (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (bus.mdu_start),
        .i_is_div (bus.id_is_div),
        .o_busy   (w_mdu_busy)
    );

    assign bus.mdu_busy = w_mdu_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (!bus.pc_write && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign bus.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scenario tasks plus randomized run, checked against a cycle-level behavioural model.
module tb_pipeline_ctrl;

    localparam int unsigned MULT_N = 4;
    localparam int unsigned DIV_N  = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pipeline_ctrl_if bus();

    pipeline_ctrl #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N),
        .CNT_W       (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          m_rem  = 0;  // model: busy cycles remaining, including the current one
    logic [31:0] m_stall = '0;

    // Vector order: pc, ifid, idex, exmem, memwb writes; ifid, idex, exmem, memwb flushes;
    // mdu_start; mdu_busy.
    function automatic logic [10:0] got_vec();
        return {bus.pc_write, bus.ifid_write, bus.idex_write, bus.exmem_write, bus.memwb_write,
                bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_flush,
                bus.mdu_start, bus.mdu_busy};
    endfunction

    function automatic logic [10:0] model_ctrl();
        logic busy, frz, lu, mh;
        busy = (m_rem > 0);
        if (rst) return {5'b00000, 4'b1111, 1'b0, busy};
        frz = bus.mem_req && !bus.mem_ready;
        lu  = bus.ex_memread && (bus.ex_rd != 5'd0) &&
              ((bus.id_uses_rs && bus.id_rs == bus.ex_rd) ||
               (bus.id_uses_rt && bus.id_rt == bus.ex_rd));
        mh  = busy && (bus.id_is_mdu || bus.id_uses_hilo);
        if (frz)                 return {5'b00000, 4'b0000, 1'b0, busy};
        if (bus.ex_branch_taken) return {5'b11111, 4'b1100, 1'b0, busy};
        if (lu || mh)            return {5'b00111, 4'b0100, 1'b0, busy};
        return {5'b11111, 4'b0000, bus.id_is_mdu, busy};
    endfunction

    task automatic model_step();
        logic [10:0] e;
        e = model_ctrl();
        if (rst) begin
            m_rem   = 0;
            m_stall = '0;
        end else begin
            if (m_rem > 0)  m_rem = m_rem - 1;
            else if (e[1])  m_rem = bus.id_is_div ? DIV_N : MULT_N;
            if (!e[10] && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rs = 0; bus.id_uses_rt = 0;
        bus.id_is_mdu = 0; bus.id_is_div = 0; bus.id_uses_hilo = 0;
        bus.ex_memread = 0; bus.ex_rd = '0; bus.ex_branch_taken = 0;
        bus.mem_req = 0; bus.mem_ready = 1;
    endtask

    task automatic rand_inputs();
        bus.id_rs           = 5'($urandom_range(0, 3));
        bus.id_rt           = 5'($urandom_range(0, 3));
        bus.id_uses_rs      = 1'($urandom_range(0, 1));
        bus.id_uses_rt      = 1'($urandom_range(0, 1));
        bus.id_is_mdu       = ($urandom_range(0, 4) == 0);
        bus.id_is_div       = 1'($urandom_range(0, 1));
        bus.id_uses_hilo    = ($urandom_range(0, 3) == 0);
        bus.ex_memread      = 1'($urandom_range(0, 1));
        bus.ex_rd           = 5'($urandom_range(0, 3));
        bus.ex_branch_taken = ($urandom_range(0, 5) == 0);
        bus.mem_req         = 1'($urandom_range(0, 1));
        bus.mem_ready       = ($urandom_range(0, 3) != 0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            rand_inputs();
            #1;
            n_cmp++;
            if (got_vec() !== model_ctrl()) begin
                n_fail++;
                $display("FAIL reset_ctrl cyc%0d got %b want %b", i, got_vec(), model_ctrl());
            end
            next_cycle();
        end
        rst = 0;
        clear_inputs();
        #1;
        n_cmp++;
        if (bus.mdu_busy !== 1'b0 || bus.stall_cycles !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_release got busy=%b stall=%0d want busy=0 stall=0",
                     bus.mdu_busy, bus.stall_cycles);
        end
        n_cmp++;
        if (got_vec() !== 11'b11111_0000_0_0) begin
            n_fail++;
            $display("FAIL reset_normal got %b want %b", got_vec(), 11'b11111_0000_0_0);
        end
        next_cycle();
    endtask

    task automatic test_load_use();
        clear_inputs();
        bus.ex_memread = 1; bus.ex_rd = 5'd8; bus.id_rs = 5'd8; bus.id_uses_rs = 1;
        #1;
        n_cmp++;
        if (got_vec() !== 11'b00111_0100_0_0) begin
            n_fail++;
            $display("FAIL load_use_stall got %b want %b", got_vec(), 11'b00111_0100_0_0);
        end
        next_cycle();
        bus.ex_memread = 0;
        #1;
        n_cmp++;
        if (bus.pc_write !== 1'b1 || bus.stall_cycles !== 32'd1) begin
            n_fail++;
            $display("FAIL load_use_clear got pc_write=%b stall=%0d want 1/1",
                     bus.pc_write, bus.stall_cycles);
        end
        next_cycle();
        bus.ex_memread = 1; bus.ex_rd = 5'd0; bus.id_rs = 5'd0; bus.id_uses_rs = 1;
        #1;
        n_cmp++;
        if (bus.pc_write !== 1'b1 || bus.idex_flush !== 1'b0) begin
            n_fail++;
            $display("FAIL load_use_r0 got pc_write=%b idex_flush=%b want 1/0",
                     bus.pc_write, bus.idex_flush);
        end
        next_cycle();
        clear_inputs();
        #1;
        n_cmp++;
        if (bus.stall_cycles !== 32'd1) begin
            n_fail++;
            $display("FAIL load_use_r0_count got %0d want 1", bus.stall_cycles);
        end
    endtask

    task automatic test_mdu(input bit is_div);
        int          stalls;
        int          n_exp;
        logic [31:0] stall0;
        n_exp = is_div ? DIV_N : MULT_N;
        clear_inputs();
        bus.id_is_mdu = 1; bus.id_is_div = is_div;
        #1;
        n_cmp++;
        if (bus.mdu_start !== 1'b1 || bus.mdu_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mdu_launch div=%0d got start=%b busy=%b want 1/0",
                     is_div, bus.mdu_start, bus.mdu_busy);
        end
        stall0 = m_stall;
        next_cycle();
        clear_inputs();
        bus.id_uses_hilo = 1;
        stalls = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            n_cmp++;
            if (got_vec() !== model_ctrl()) begin
                n_fail++;
                $display("FAIL mdu_hilo div=%0d cyc%0d got %b want %b",
                         is_div, i, got_vec(), model_ctrl());
            end
            if (bus.pc_write === 1'b1) break;
            stalls++;
            next_cycle();
        end
        n_cmp++;
        if (stalls != n_exp || bus.stall_cycles !== stall0 + 32'(n_exp)) begin
            n_fail++;
            $display("FAIL mdu_stall_len div=%0d got %0d cycles (counter %0d) want %0d (%0d)",
                     is_div, stalls, bus.stall_cycles, n_exp, stall0 + 32'(n_exp));
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_freeze_branch();
        logic [31:0] stall0;
        stall0 = m_stall;
        clear_inputs();
        bus.mem_req = 1; bus.mem_ready = 0; bus.ex_branch_taken = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (got_vec() !== 11'b00000_0000_0_0) begin
                n_fail++;
                $display("FAIL freeze cyc%0d got %b want %b", i, got_vec(), 11'b0);
            end
            next_cycle();
        end
        bus.mem_ready = 1;
        #1;
        n_cmp++;
        if (got_vec() !== 11'b11111_1100_0_0 || bus.stall_cycles !== stall0 + 32'd3) begin
            n_fail++;
            $display("FAIL freeze_release got %b stall=%0d want %b stall=%0d",
                     got_vec(), bus.stall_cycles, 11'b11111_1100_0_0, stall0 + 32'd3);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_branch_mdu();
        clear_inputs();
        bus.ex_branch_taken = 1; bus.id_is_mdu = 1;
        #1;
        n_cmp++;
        if (bus.mdu_start !== 1'b0) begin
            n_fail++;
            $display("FAIL branch_mdu_start got %b want 0", bus.mdu_start);
        end
        next_cycle();
        clear_inputs();
        #1;
        n_cmp++;
        if (bus.mdu_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL branch_mdu_busy got %b want 0", bus.mdu_busy);
        end
    endtask

    task automatic test_reset_mid_div();
        clear_inputs();
        bus.id_is_mdu = 1; bus.id_is_div = 1;
        #1;
        next_cycle();
        clear_inputs();
        for (int i = 0; i < 9; i++) next_cycle();
        #1;
        n_cmp++;
        if (bus.mdu_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL div_busy_pre_reset got %b want 1", bus.mdu_busy);
        end
        rst = 1;
        next_cycle();
        rst = 0;
        #1;
        n_cmp++;
        if (bus.mdu_busy !== 1'b0 || bus.stall_cycles !== 32'd0) begin
            n_fail++;
            $display("FAIL div_abort got busy=%b stall=%0d want 0/0",
                     bus.mdu_busy, bus.stall_cycles);
        end
        bus.id_uses_hilo = 1;
        #1;
        n_cmp++;
        if (bus.pc_write !== 1'b1) begin
            n_fail++;
            $display("FAIL div_abort_mfhi got pc_write=%b want 1", bus.pc_write);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rand_inputs();
            rst = ($urandom_range(0, 59) == 0);
            #1;
            n_cmp++;
            if (got_vec() !== model_ctrl() || bus.stall_cycles !== m_stall) begin
                n_fail++;
                $display("FAIL random cyc%0d got %b stall=%0d want %b stall=%0d",
                         i, got_vec(), bus.stall_cycles, model_ctrl(), m_stall);
            end
            next_cycle();
        end
        rst = 0;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        @(negedge clk);
        test_reset();
        test_load_use();
        test_mdu(1'b0);
        test_mdu(1'b1);
        test_freeze_branch();
        test_branch_mdu();
        test_reset_mid_div();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and sequencing controller for the 32-bit five-stage MIPS pipeline. It drives the `write`/`flush` controls of the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers and the PC write enable. It resolves data-memory wait states, taken branches/jumps, load-use hazards and HI/LO hazards against the multi-cycle multiply/divide unit (MDU). It also sequences the MDU busy window and keeps a stall-cycle performance counter.

## Interface
- `MULT_CYCLES`, 4, MDU latency for mult/multu (≥1)
- `DIV_CYCLES`, 32, MDU latency for div/divu (≥1)
- `CNT_W`, 6, MDU counter width; must hold `max(MULT_CYCLES, DIV_CYCLES) - 1`

Ports:
- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-high
- `id_rs`, `id_rt` in 5: source registers of the instruction in ID
- `id_uses_rs`, `id_uses_rt` in 1: ID instruction actually reads rs/rt
- `id_is_mdu` in 1: ID holds mult/multu/div/divu
- `id_is_div` in 1: qualifies `id_is_mdu` as a divide
- `id_uses_hilo` in 1: ID holds mfhi/mflo/mthi/mtlo
- `ex_memread` in 1: EX holds a load
- `ex_rd` in 5: destination register of the EX instruction
- `ex_branch_taken` in 1: branch/jump resolved taken in EX
- `mem_req` in 1: MEM stage accessing data memory
- `mem_ready` in 1: data memory completes this cycle
- `pc_write`, `ifid_write`, `idex_write`, `exmem_write`, `memwb_write` out 1: stage load enables
- `ifid_flush`, `idex_flush`, `exmem_flush`, `memwb_flush` out 1: stage clears, sampled synchronously
- `mdu_start` out 1: one-cycle MDU launch pulse
- `mdu_busy` out 1: MDU result not yet valid
- `stall_cycles` out 32: saturating count of cycles with `pc_write`=0

## Operation
- All control outputs are combinational from the registered state and the inputs. The registered state is the MDU FSM, its counter and `stall_cycles`.
- While `rst`=1: all `*_write`=0, all `*_flush`=1, `mdu_start`=0. The next edge sets MDU state to IDLE, counter to 0 and `stall_cycles` to 0.
- Hazard conditions:
  - **freeze** = `mem_req` & !`mem_ready`
  - **load_use** = `ex_memread` & `ex_rd`≠0 & ((`id_uses_rs` & `id_rs`=`ex_rd`) | (`id_uses_rt` & `id_rt`=`ex_rd`))
  - **mdu_haz** = `mdu_busy` & (`id_is_mdu` | `id_uses_hilo`)
- Priority when not in reset is freeze > branch > mdu_haz/load_use > normal.
  - **freeze:** all writes 0, all flushes 0, `mdu_start`=0.
  - **branch** (`ex_branch_taken`): all writes 1, `ifid_flush`=`idex_flush`=1, `mdu_start`=0, because the ID instruction is squashed.
  - **mdu_haz or load_use:** `pc_write`=`ifid_write`=0, `idex_write`=1, `idex_flush`=1 (bubble), later stages write 1, `mdu_start`=0.
  - **normal:** all writes 1, all flushes 0, `mdu_start`=`id_is_mdu`.
- `exmem_flush` and `memwb_flush` are asserted only in reset.
- MDU FSM:
  - **IDLE:** when `mdu_start`=1, go to BUSY and load counter with `id_is_div` ? `DIV_CYCLES`-1 : `MULT_CYCLES`-1.
  - **BUSY:** when counter=0, go to IDLE; otherwise decrement. The counter advances during freeze.
  - `mdu_busy` = (state==BUSY).
- `stall_cycles`: increments at each non-reset edge where `pc_write`=0 (freeze or hazard stall) and holds at 0xFFFFFFFF.

## Timing
- Load-use stall costs exactly 1 cycle. The next cycle the load is in MEM and the hazard clears.
- MDU: if `mdu_start` is high in cycle T, `mdu_busy` is high in cycles T+1 through T+N, where N is the selected latency. A dependent mfhi/mflo or a second mult/div in ID advances no earlier than cycle T+N+1.
- Freeze lasts exactly the cycles with `mem_ready`=0. The pipeline resumes in the same cycle `mem_ready` rises.
- Freeze coinciding with a taken branch: nothing is flushed while frozen. The branch stays in EX and flushes in the first unfrozen cycle.
- Branch coinciding with `id_is_mdu`: no start and the MDU stays IDLE.
- Reset mid-BUSY aborts the MDU: `mdu_busy`=0 after the reset edge.

## Structure
- Shared package `pipe_pkg`:
  - MDU state enum (IDLE, BUSY)
  - Default `MULT_CYCLES`/`DIV_CYCLES`
  - Register-index width constant (5)
- Sub-module `mdu_sequencer`: FSM, counter, `mdu_busy`. Its inputs are `mdu_start`, `id_is_div` and `rst`.
- Top level: hazard priority logic and `stall_cycles`.

## Test plan
- **Reset:** hold `rst` for 2 cycles → all flushes 1, writes 0; after release `mdu_busy`=0, `stall_cycles`=0.
- **Load-use:** `ex_memread`=1, `ex_rd`=8, `id_rs`=8, `id_uses_rs`=1 → 1 cycle with `pc_write`=0 and `idex_flush`=1, `stall_cycles`=1. Repeat with `ex_rd`=0 → no stall.
- **MDU hazard:** mult accepted at T, then mfhi in ID → `mdu_busy` high T+1..T+4, `pc_write`=0 for 4 cycles, mfhi advances at T+5. Repeat with div → 32-cycle stall.
- **Memory freeze:** `mem_req`=1, `mem_ready`=0 for 3 cycles while `ex_branch_taken`=1 → all writes 0, no flushes. When `mem_ready` rises, `ifid_flush`=`idex_flush`=1.
- **Branch vs MDU:** `ex_branch_taken`=1 and `id_is_mdu`=1 in the same cycle → `mdu_start`=0, `mdu_busy` stays 0.
- **Reset mid-divide:** `rst` asserted 10 cycles after a div start → `mdu_busy`=0 after the reset edge, and a subsequent mfhi is not stalled.
